intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Parametrised interrupt controller for the monocycle CPU. Generalises the two fixed interrupt lines to N_IRQ channels.
- Each channel is configurable as edge or level triggered. Channels have per-channel masking and fixed priority (lowest index wins).
- Presents one request/vector/acknowledge/return handshake to the CPU core.
- Sits between external interrupt sources and the CPU's PC-select logic.

Parameters:
N_IRQ, 4, number of interrupt channels (2..16)
VEC_W, 10, width of vector output (CPU PC width)
VEC_BASE, 10'h3F0, vector of channel 0
VEC_STRIDE, 2, vector spacing between channels
EDGE_MASK, 4'b1111, bit i=1: channel i rising-edge triggered; 0: level (high) triggered
MASK_RST, 4'b1111, reset value of enable mask (1=enabled)
ID_W, $clog2(N_IRQ), width of channel id

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
irq_in  in  N_IRQ  raw asynchronous interrupt sources
irq_en  in  1  CPU global interrupt enable
mask_we  in  1  write strobe for enable mask
mask_wdata  in  N_IRQ  new mask value
irq_req  out  1  interrupt request to CPU
irq_id  out  ID_W  id of requested channel
irq_vec  out  VEC_W  handler address = VEC_BASE + irq_id*VEC_STRIDE, truncated to VEC_W
irq_ack  in  1  one-cycle pulse: CPU has taken the vector
irq_ret  in  1  one-cycle pulse: CPU executed return-from-interrupt
irq_pend  out  N_IRQ  pending status
irq_mask  out  N_IRQ  current mask
in_service  out  N_IRQ  in-service status

Behaviour:
- Reset (reset=0, async): sync flops=0; pend=0; in_service=0; irq_mask=MASK_RST; state=IDLE; irq_req=0; irq_id=0; irq_vec=0. Reset mid-handshake aborts everything; nothing is retained.
- Synchroniser: 2-flop per channel (s1, s2), plus s2_d for edge detection.
- Edge channel: pend[i] set on s2 & ~s2_d. Cleared only when ack'd for channel i. Set wins over clear in the same cycle.
- Level channel: pend[i] = s2 (registered). Not cleared by ack; the source must drop it.
- Masking: mask_we loads irq_mask next edge. Masked edge pends stay latched but are not eligible. Eligible = pend & irq_mask & ~in_service.
- Latency: irq_in high before edge E0 -> s2 after E1 -> pend after E2 -> irq_req after E3, assuming IDLE and irq_en=1.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if irq_en & |eligible, latch lowest-index eligible into irq_id/irq_vec; irq_req<=1; ->REQ.
  - REQ: hold irq_req, irq_id, irq_vec stable regardless of mask/irq_en/source changes. On irq_ack: irq_req<=0; in_service[id]<=1; clear pend[id] if edge; ->SERVICE.
  - SERVICE: on irq_ret: clear highest-priority set in_service bit; ->IDLE when in_service becomes 0.
- IDLE re-arbitrates on the cycle after return, so back-to-back service is possible with one idle cycle minimum.
- Ignored events: irq_ack outside REQ; irq_ret outside SERVICE. irq_ack and irq_ret in the same cycle: ret ignored.
- Multiple simultaneous edges: all latch; serviced in index order.

Optional Feature:
INTC_NEST_EN
- Defined: in SERVICE, if irq_en and an eligible channel has index lower than the lowest set in_service bit, latch it and ->REQ (nested). Ack adds its in_service bit. Each irq_ret clears the lowest-index set in_service bit. Returns to IDLE only when in_service==0. Max nesting depth N_IRQ.
- Undefined: no request is raised while in SERVICE; at most one in_service bit is set.

Test Plan:
1. Reset held low 10 cycles with irq_in=4'b1111 -> irq_req=0, pend=0, irq_mask=4'b1111; release -> irq_req rises at 3rd edge after the first sampled edge, irq_id=0, irq_vec=10'h3F0.
2. Edge pulse on ch2 only, irq_en=1 -> irq_id=2, irq_vec=10'h3F4; ack -> pend[2]=0, in_service=4'b0100; ret -> in_service=0, IDLE.
3. Simultaneous edges ch1, ch3 -> ch1 (vec 10'h3F2) first; after its ret, ch3 (vec 10'h3F6) requested after 1 idle cycle.
4. mask_wdata=4'b1110, edge ch0 -> pend[0]=1, no irq_req; unmask -> irq_req with id 0.
5. Level channel (EDGE_MASK=4'b1110) ch0 held high through ack and ret -> re-requested; dropped -> no further request. Also: irq_ack with irq_req=0 -> no state change.
6. INTC_NEST_EN: servicing ch3, edge on ch1 -> nested request id 1; ack -> in_service=4'b1010; ret -> 4'b1000; ret -> 0. Without macro: ch1 waits until ch3 returns.

Source files
------------

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - N-channel edge/level interrupt controller with fixed priority; optional nesting via INTC_NEST_EN
module intr_ctrl #(
    parameter int               N_IRQ      = 4,
    parameter int               VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3F0,
    parameter int               VEC_STRIDE = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = 4'b1111,
    parameter logic [N_IRQ-1:0] MASK_RST   = 4'b1111,
    parameter int               ID_W       = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             irq_en,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_ret,
    output logic [N_IRQ-1:0] irq_pend,
    output logic [N_IRQ-1:0] irq_mask,
    output logic [N_IRQ-1:0] in_service
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]       state;
    logic [N_IRQ-1:0] s1, s2, s2_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] ack_onehot;
    logic [N_IRQ-1:0] is_pop;
    logic [ID_W-1:0]  arb_id;
    logic             ack_fire;
    logic             nest_hit;

    // Lowest set index wins; returns 0 for an empty vector (callers gate on |v).
    function automatic logic [ID_W-1:0] lowest(input logic [N_IRQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) r = i[ID_W-1:0];
        end
        return r;
    endfunction

    // Handler address, computed wide and truncated to the PC width.
    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        logic [31:0] t;
        t = 32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE);
        return t[VEC_W-1:0];
    endfunction

    // Arbitration, handshake qualifiers and the in_service pop value.
    always_comb begin
        rise       = s2 & ~s2_d;
        eligible   = irq_pend & irq_mask & ~in_service;
        arb_id     = lowest(eligible);
        ack_fire   = (state == REQ) && irq_ack;
        ack_onehot = ack_fire ? (N_IRQ'(1) << irq_id) : '0;
        // Clearing the lowest set bit is the highest-priority in-service channel.
        is_pop     = in_service & (in_service - N_IRQ'(1));
        nest_hit   = 1'b0;
`ifdef INTC_NEST_EN
        // Only channels strictly above (lower index than) every in-service channel may preempt.
        begin
            logic             found;
            logic [N_IRQ-1:0] below;
            found = 1'b0;
            below = '0;
            for (int i = 0; i < N_IRQ; i++) begin
                if (in_service[i]) found = 1'b1;
                below[i] = ~found;
            end
            nest_hit = irq_en && |(eligible & below);
        end
`endif
    end

    // Two-flop synchroniser plus delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            s2_d <= '0;
        end else begin
            s1   <= irq_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // Enable mask register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask <= MASK_RST;
        end else if (mask_we) begin
            irq_mask <= mask_wdata;
        end
    end

    // Pending: edge channels latch until acked (new edge beats the clear); level channels track the source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend <= '0;
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (EDGE_MASK[i]) irq_pend[i] <= rise[i] | (irq_pend[i] & ~ack_onehot[i]);
                else              irq_pend[i] <= s2[i];
            end
        end
    end

    // Request/acknowledge/return FSM; request outputs are frozen while in REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            irq_vec    <= '0;
            in_service <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (irq_en && |eligible) begin
                        irq_id  <= arb_id;
                        irq_vec <= vec_of(arb_id);
                        irq_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        irq_req    <= 1'b0;
                        in_service <= in_service | ack_onehot;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (irq_ret) begin
                        in_service <= is_pop;
                        if (is_pop == '0) state <= IDLE;
                    end else if (nest_hit) begin
                        irq_id  <= arb_id;
                        irq_vec <= vec_of(arb_id);
                        irq_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl (all-edge instance and level-ch0 instance)
module tb_intr_ctrl;

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] a_irq = 4'b1111, a_mwd = '0, a_pend, a_mask, a_is;
    logic       a_en = 1'b1, a_mwe = 1'b0, a_ack = 1'b0, a_ret = 1'b0, a_req;
    logic [1:0] a_id;
    logic [9:0] a_vec;

    logic [3:0] b_irq = '0, b_mwd = '0, b_pend, b_mask, b_is;
    logic       b_en = 1'b1, b_mwe = 1'b0, b_ack = 1'b0, b_ret = 1'b0, b_req;
    logic [1:0] b_id;
    logic [9:0] b_vec;

    int checks = 0;
    int failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic a_req_q = 1'b0, b_req_q = 1'b0;

    intr_ctrl u_a (
        .clk(clk), .reset(reset), .irq_in(a_irq), .irq_en(a_en),
        .mask_we(a_mwe), .mask_wdata(a_mwd), .irq_req(a_req), .irq_id(a_id),
        .irq_vec(a_vec), .irq_ack(a_ack), .irq_ret(a_ret), .irq_pend(a_pend),
        .irq_mask(a_mask), .in_service(a_is)
    );

    intr_ctrl #(.EDGE_MASK(4'b1110)) u_b (
        .clk(clk), .reset(reset), .irq_in(b_irq), .irq_en(b_en),
        .mask_we(b_mwe), .mask_wdata(b_mwd), .irq_req(b_req), .irq_id(b_id),
        .irq_vec(b_vec), .irq_ack(b_ack), .irq_ret(b_ret), .irq_pend(b_pend),
        .irq_mask(b_mask), .in_service(b_is)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: each new request is popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset && a_req && !a_req_q) begin
            if (q_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_req actual_id=%0d expected=none", a_id);
            end else begin
                e = q_a.pop_front();
                chk("a_req_id", 32'(a_id), 32'(e.id));
                chk("a_req_vec", 32'(a_vec), 32'(e.vec));
            end
        end
        if (reset && b_req && !b_req_q) begin
            if (q_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_req actual_id=%0d expected=none", b_id);
            end else begin
                e = q_b.pop_front();
                chk("b_req_id", 32'(b_id), 32'(e.id));
                chk("b_req_vec", 32'(b_vec), 32'(e.vec));
            end
        end
        a_req_q = a_req;
        b_req_q = b_req;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel ? b_req : a_req) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_req_timeout sel=%0d actual=0 expected=1", sel);
        end
    endtask

    task automatic pulse_ack(input bit sel);
        @(posedge clk); #1;
        if (sel) b_ack = 1'b1; else a_ack = 1'b1;
        @(posedge clk); #1;
        a_ack = 1'b0; b_ack = 1'b0;
    endtask

    task automatic pulse_ret(input bit sel);
        @(posedge clk); #1;
        if (sel) b_ret = 1'b1; else a_ret = 1'b1;
        @(posedge clk); #1;
        a_ret = 1'b0; b_ret = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        @(posedge clk); #1;
        a_irq = v;
        repeat (2) @(posedge clk);
        #1;
        a_irq = '0;
    endtask

    task automatic write_mask(input logic [3:0] v);
        @(posedge clk); #1;
        a_mwe = 1'b1; a_mwd = v;
        @(posedge clk); #1;
        a_mwe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // 1: reset with all sources high, then first-request latency
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(a_req), 0);
        chk("rst_pend", 32'(a_pend), 0);
        chk("rst_mask", 32'(a_mask), 32'hF);
        chk("rst_is", 32'(a_is), 0);
        chk("rst_vec", 32'(a_vec), 0);
        q_a.push_back('{id: 2'd0, vec: 10'h3F0});
        q_a.push_back('{id: 2'd1, vec: 10'h3F2});
        q_a.push_back('{id: 2'd2, vec: 10'h3F4});
        q_a.push_back('{id: 2'd3, vec: 10'h3F6});
        @(posedge clk); #1;
        reset = 1'b1;
        cycles(3);
        chk("lat_req_e2", 32'(a_req), 0);
        chk("lat_pend_e2", 32'(a_pend), 32'hF);
        cycles(1);
        chk("lat_req_e3", 32'(a_req), 1);
        a_irq = '0;
        for (int k = 0; k < 4; k++) begin
            wait_req(0);
            pulse_ack(0);
            chk("drain_is", 32'(a_is), 32'(1 << k));
            pulse_ret(0);
        end
        chk("drain_is_end", 32'(a_is), 0);

        // 2: single edge on ch2
        q_a.push_back('{id: 2'd2, vec: 10'h3F4});
        pulse_irq(4'b0100);
        wait_req(0);
        pulse_ack(0);
        chk("t2_pend", 32'(a_pend), 0);
        chk("t2_is", 32'(a_is), 32'h4);
        pulse_ret(0);
        chk("t2_is_ret", 32'(a_is), 0);
        chk("t2_req_ret", 32'(a_req), 0);

        // 3: simultaneous edges ch1+ch3, one idle cycle between services
        q_a.push_back('{id: 2'd1, vec: 10'h3F2});
        q_a.push_back('{id: 2'd3, vec: 10'h3F6});
        pulse_irq(4'b1010);
        wait_req(0);
        pulse_ack(0);
        chk("t3_pend", 32'(a_pend), 32'h8);
        pulse_ret(0);
        chk("t3_idle_gap", 32'(a_req), 0);
        cycles(1);
        chk("t3_rearb", 32'(a_req), 1);
        pulse_ack(0);
        pulse_ret(0);

        // 4: masked edge stays pending, request on unmask
        write_mask(4'b1110);
        chk("t4_mask", 32'(a_mask), 32'hE);
        pulse_irq(4'b0001);
        cycles(6);
        chk("t4_pend_masked", 32'(a_pend), 32'h1);
        chk("t4_req_masked", 32'(a_req), 0);
        q_a.push_back('{id: 2'd0, vec: 10'h3F0});
        write_mask(4'b1111);
        wait_req(0);
        pulse_ack(0);
        chk("t4_pend_ack", 32'(a_pend), 0);
        pulse_ret(0);

        // 5: level ch0 on u_b; stray ack first
        pulse_ack(1);
        chk("t5_stray_is", 32'(b_is), 0);
        chk("t5_stray_req", 32'(b_req), 0);
        q_b.push_back('{id: 2'd0, vec: 10'h3F0});
        q_b.push_back('{id: 2'd0, vec: 10'h3F0});
        b_irq = 4'b0001;
        wait_req(1);
        pulse_ack(1);
        chk("t5_level_pend", 32'(b_pend), 32'h1);
        chk("t5_is", 32'(b_is), 32'h1);
        pulse_ret(1);
        wait_req(1);
        pulse_ack(1);
        b_irq = '0;
        cycles(5);
        pulse_ret(1);
        cycles(8);
        chk("t5_no_rereq", 32'(b_req), 0);
        chk("t5_pend_drop", 32'(b_pend), 0);

        // 6: ch1 arrives while ch3 is in service
        q_a.push_back('{id: 2'd3, vec: 10'h3F6});
        pulse_irq(4'b1000);
        wait_req(0);
        pulse_ack(0);
        chk("t6_is3", 32'(a_is), 32'h8);
        q_a.push_back('{id: 2'd1, vec: 10'h3F2});
        pulse_irq(4'b0010);
`ifdef INTC_NEST_EN
        wait_req(0);
        pulse_ack(0);
        chk("t6_nest_is", 32'(a_is), 32'hA);
        pulse_ret(0);
        chk("t6_ret1_is", 32'(a_is), 32'h8);
        pulse_ret(0);
        chk("t6_ret2_is", 32'(a_is), 0);
`else
        cycles(6);
        chk("t6_wait_req", 32'(a_req), 0);
        chk("t6_wait_pend", 32'(a_pend), 32'h2);
        pulse_ret(0);
        chk("t6_ret_is", 32'(a_is), 0);
        wait_req(0);
        pulse_ack(0);
        chk("t6_is1", 32'(a_is), 32'h2);
        pulse_ret(0);
`endif

        cycles(6);
        chk("sb_a_empty", 32'(q_a.size()), 0);
        chk("sb_b_empty", 32'(q_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
